// File: rtl/stall_flush_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and
// perf-counter slot indices.
package rv32i_types;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DWAIT = 2'd1,
        ST_IWAIT = 2'd2,
        ST_RHOLD = 2'd3
    } ctrl_state_t;

    localparam int PERF_DMISS = 0;
    localparam int PERF_IMISS = 1;
    localparam int PERF_LUSE  = 2;
    localparam int PERF_FLUSH = 3;
    localparam int NUM_PERF   = 4;

endpackage

// File: rtl/stall_flush_ctrl_sat_counter.sv
// Saturating event counter. A clear takes priority over an increment.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (clr)
            r_cnt <= '0;
        else if (inc && (r_cnt != {CNT_W{1'b1}}))
            r_cnt <= r_cnt + 1'b1;
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/stall_flush_ctrl.sv
// Pipeline stall/flush controller: combinational hazard resolution, a wait-state
// FSM feeding a hang watchdog, and per-cause performance counters.
module stall_flush_ctrl
    import rv32i_types::*;
#(
    parameter int NUM_STAGES = 5,
    parameter int EX_STAGE   = 2,
    parameter int MEM_STAGE  = 3,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = 1023
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_read,
    input  logic                        i_resp,
    input  logic                        d_read,
    input  logic                        d_write,
    input  logic                        d_resp,
    input  logic                        ex_is_load,
    input  logic [4:0]                  ex_rd,
    input  logic [4:0]                  id_rs1,
    input  logic [4:0]                  id_rs2,
    input  logic                        redirect,
    input  logic                        perf_clr,
    output logic [NUM_STAGES-1:0]       stall,
    output logic [NUM_STAGES-1:0]       bubble,
    output logic [1:0]                  state_o,
    output logic                        hang,
    output logic [3:0][CNT_W-1:0]       perf_cnt
);

    localparam int WD_W = $clog2(TIMEOUT + 1);

    logic              w_dmiss, w_imiss, w_luse;
    logic [3:0]        w_win;
    ctrl_state_t       r_state, w_state_nxt;
    logic [WD_W-1:0]   r_wd, w_wd_nxt;
    logic              r_hang;

    assign w_dmiss = (d_read | d_write) & ~d_resp;
    assign w_imiss = i_read & ~i_resp;
    assign w_luse  = ex_is_load & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

    // Exactly one cause wins each cycle; redirect+imiss is still a redirect cycle.
    assign w_win[PERF_DMISS] = w_dmiss;
    assign w_win[PERF_FLUSH] = ~w_dmiss & redirect;
    assign w_win[PERF_LUSE]  = ~w_dmiss & ~redirect & w_luse;
    assign w_win[PERF_IMISS] = ~w_dmiss & ~redirect & ~w_luse & w_imiss;

    always_comb begin
        stall  = '0;
        bubble = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (w_dmiss) begin
                stall[i]  = (i <= MEM_STAGE);
                bubble[i] = (i == MEM_STAGE + 1);
            end else if (redirect && w_imiss) begin
                // Keep the branch in EX until fetch settles so the target is not lost.
                stall[i]  = (i <= EX_STAGE);
            end else if (redirect) begin
                bubble[i] = (i >= 1) && (i <= EX_STAGE);
            end else if (w_luse) begin
                stall[i]  = (i <= 1);
                bubble[i] = (i == 2);
            end else if (w_imiss) begin
                stall[i]  = (i == 0);
                bubble[i] = (i == 1);
            end
        end
    end

    always_comb begin
        w_state_nxt = ST_RUN;
        if (w_dmiss)
            w_state_nxt = ST_DWAIT;
        else if (redirect && w_imiss)
            w_state_nxt = ST_RHOLD;
        else if (w_imiss)
            w_state_nxt = ST_IWAIT;
    end

    always_comb begin
        w_wd_nxt = '0;
        if (r_state != ST_RUN)
            w_wd_nxt = (r_wd == WD_W'(TIMEOUT)) ? r_wd : r_wd + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_RUN;
            r_wd    <= '0;
            r_hang  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_wd    <= w_wd_nxt;
            r_hang  <= r_hang | (w_wd_nxt == WD_W'(TIMEOUT));
        end
    end

    assign state_o = r_state;
    assign hang    = r_hang;

    for (genvar k = 0; k < NUM_PERF; k++) begin : g_perf
        sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk (clk),
            .rst (rst),
            .inc (w_win[k]),
            .clr (perf_clr),
            .cnt (perf_cnt[k])
        );
    end

endmodule

// File: tb/tb_stall_flush_ctrl.sv
// Directed bench for stall_flush_ctrl: default instance plus a small
// TIMEOUT/CNT_W instance for watchdog and saturation behaviour.
module tb_stall_flush_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic i_read, i_resp, d_read, d_write, d_resp, ex_is_load, redirect, perf_clr;
    logic [4:0] ex_rd, id_rs1, id_rs2;
    logic [4:0] stall, bubble, stall2, bubble2;
    logic [1:0] state_o, state2;
    logic hang, hang2;
    logic [3:0][31:0] perf;
    logic [3:0][2:0]  perf2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    stall_flush_ctrl dut (
        .clk(clk), .rst(rst), .i_read(i_read), .i_resp(i_resp), .d_read(d_read),
        .d_write(d_write), .d_resp(d_resp), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .redirect(redirect), .perf_clr(perf_clr),
        .stall(stall), .bubble(bubble), .state_o(state_o), .hang(hang), .perf_cnt(perf)
    );

    stall_flush_ctrl #(.TIMEOUT(4), .CNT_W(3)) dut2 (
        .clk(clk), .rst(rst), .i_read(i_read), .i_resp(i_resp), .d_read(d_read),
        .d_write(d_write), .d_resp(d_resp), .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .redirect(redirect), .perf_clr(perf_clr),
        .stall(stall2), .bubble(bubble2), .state_o(state2), .hang(hang2), .perf_cnt(perf2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs are then changed at posedge+1.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_read = 0; i_resp = 0; d_read = 0; d_write = 0; d_resp = 0;
        ex_is_load = 0; ex_rd = 0; id_rs1 = 0; id_rs2 = 0; redirect = 0; perf_clr = 0;
    endtask

    initial begin
        idle();
        rst = 1;
        #3;
        chk("rst_state", 32'(state_o), 32'd0);
        chk("rst_hang", 32'(hang), 32'd0);
        chk("rst_perf0", perf[0], 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);
        tick();
        rst = 0;
        tick();

        // Data miss held for three cycles
        d_read = 1; d_resp = 0; #1;
        chk("dmiss_c1_stall", 32'(stall), 32'h0F);
        chk("dmiss_c1_bubble", 32'(bubble), 32'h10);
        chk("dmiss_c1_state", 32'(state_o), 32'd0);
        tick(); #1;
        chk("dmiss_c2_stall", 32'(stall), 32'h0F);
        chk("dmiss_c2_state", 32'(state_o), 32'd1);
        tick(); #1;
        chk("dmiss_c3_bubble", 32'(bubble), 32'h10);
        chk("dmiss_c3_state", 32'(state_o), 32'd1);
        tick();
        d_resp = 1; #1;
        chk("dmiss_resp_stall", 32'(stall), 32'h00);
        chk("dmiss_perf0", perf[0], 32'd3);
        tick();
        idle(); #1;
        chk("dmiss_back_run", 32'(state_o), 32'd0);

        // Load-use hazard
        ex_is_load = 1; ex_rd = 5; id_rs2 = 5; #1;
        chk("luse_stall", 32'(stall), 32'h03);
        chk("luse_bubble", 32'(bubble), 32'h04);
        tick();
        ex_rd = 0; id_rs1 = 0; id_rs2 = 0; #1;
        chk("luse_x0_stall", 32'(stall), 32'h00);
        chk("luse_perf2", perf[2], 32'd1);
        idle();

        // Redirect while fetch is missing
        redirect = 1; i_read = 1; i_resp = 0; #1;
        chk("rhold_c1_stall", 32'(stall), 32'h07);
        chk("rhold_c1_bubble", 32'(bubble), 32'h00);
        tick(); #1;
        chk("rhold_c2_stall", 32'(stall), 32'h07);
        chk("rhold_c2_state", 32'(state_o), 32'd3);
        tick();
        i_resp = 1; #1;
        chk("rhold_resp_stall", 32'(stall), 32'h00);
        chk("rhold_resp_bubble", 32'(bubble), 32'h06);
        chk("rhold_resp_state", 32'(state_o), 32'd3);
        tick();
        idle(); #1;
        chk("redir_perf3", perf[3], 32'd3);
        chk("redir_perf1", perf[1], 32'd0);

        // All three causes together: data miss wins
        d_read = 1; redirect = 1; ex_is_load = 1; ex_rd = 7; id_rs1 = 7; #1;
        chk("prio_stall", 32'(stall), 32'h0F);
        chk("prio_bubble", 32'(bubble), 32'h10);
        tick();
        idle(); #1;
        chk("prio_perf0", perf[0], 32'd4);
        chk("prio_perf2", perf[2], 32'd1);
        chk("prio_perf3", perf[3], 32'd3);

        // Instruction miss alone
        i_read = 1; #1;
        chk("imiss_stall", 32'(stall), 32'h01);
        chk("imiss_bubble", 32'(bubble), 32'h02);
        tick(); #1;
        chk("imiss_state", 32'(state_o), 32'd2);
        idle();
        tick();

        // Same-cycle response: no stall
        d_write = 1; d_resp = 1; #1;
        chk("zero_lat_stall", 32'(stall), 32'h00);
        tick(); #1;
        chk("zero_lat_state", 32'(state_o), 32'd0);
        idle();

        // Async reset in the middle of a wait
        d_read = 1; tick(); #1;
        chk("pre_rst_state", 32'(state_o), 32'd1);
        #2 rst = 1; #1;
        chk("mid_rst_state", 32'(state_o), 32'd0);
        chk("mid_rst_perf0", perf[0], 32'd0);
        chk("mid_rst_stall", 32'(stall), 32'h0F);
        rst = 0;
        idle();
        tick();

        // Watchdog on the TIMEOUT=4 instance
        d_read = 1;
        tick(); tick(); tick(); tick(); #1;
        chk("wd_before", 32'(hang2), 32'd0);
        tick(); #1;
        chk("wd_rise", 32'(hang2), 32'd1);
        chk("wd_default_quiet", 32'(hang), 32'd0);
        d_resp = 1; tick(); tick(); #1;
        chk("wd_sticky", 32'(hang2), 32'd1);
        idle();
        rst = 1; #1;
        chk("wd_rst_clear", 32'(hang2), 32'd0);
        rst = 0;
        tick();

        // Saturation on the CNT_W=3 instance
        i_read = 1;
        for (int n = 0; n < 9; n++) tick();
        #1;
        chk("sat_perf1", 32'(perf2[1]), 32'd7);
        chk("nosat_perf1", perf[1], 32'd9);
        perf_clr = 1;
        tick(); #1;
        chk("clr_perf1", 32'(perf2[1]), 32'd0);
        idle();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/stall_flush_ctrl.md
STALL_FLUSH_CTRL -- requirements
Module: stall_flush_ctrl

Interface
REQ-001 Parameter NUM_STAGES, default 5: pipeline register count, index 0 = PC, 1 = IF/ID, ... NUM_STAGES-1 = MEM/WB.
REQ-002 Parameter EX_STAGE, default 2: index of the register feeding EX (ID/EX).
REQ-003 Parameter MEM_STAGE, default 3: index of the register feeding MEM (EX/MEM).
REQ-004 Parameter CNT_W, default 32: perf counter width.
REQ-005 Parameter TIMEOUT, default 1023: max wait cycles before hang flag.
REQ-006 clk  in  1  clock, all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 i_read  in  1  instruction fetch request.
REQ-009 i_resp  in  1  instruction fetch complete.
REQ-010 d_read  in  1  data load request.
REQ-011 d_write  in  1  data store request.
REQ-012 d_resp  in  1  data access complete.
REQ-013 ex_is_load  in  1  ID/EX holds a load.
REQ-014 ex_rd  in  5  ID/EX destination register.
REQ-015 id_rs1  in  5  IF/ID source 1.
REQ-016 id_rs2  in  5  IF/ID source 2.
REQ-017 redirect  in  1  EX branch/jump mispredict; held by datapath while EX stalled.
REQ-018 perf_clr  in  1  synchronous clear of all perf counters.
REQ-019 stall  out  NUM_STAGES  1 = hold register i.
REQ-020 bubble  out  NUM_STAGES  1 = load nop into register i.
REQ-021 state_o  out  2  current FSM state.
REQ-022 hang  out  1  sticky watchdog flag.
REQ-023 perf_cnt  out  4 x CNT_W  [0] dmiss, [1] imiss, [2] load-use, [3] flush cycles.

Function
REQ-024 dmiss = (d_read|d_write)&!d_resp; imiss = i_read&!i_resp; luse = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-025 Outputs combinational from inputs; one cause active per cycle, priority dmiss > redirect > luse > imiss.
REQ-026 dmiss: stall[0..MEM_STAGE]=1; bubble[MEM_STAGE+1]=1 only if MEM_STAGE+1 < NUM_STAGES.
REQ-027 redirect, no dmiss, no imiss: bubble[1..EX_STAGE]=1, stall all 0 (PC loads target).
REQ-028 redirect with imiss: stall[0..EX_STAGE]=1 (branch held in EX, fetch address stable) until i_resp; on i_resp cycle apply REQ-027.
REQ-029 luse (no redirect, no dmiss): stall[0..1]=1, bubble[2]=1, exactly one cycle per load.
REQ-030 imiss alone: stall[0]=1, bubble[1]=1.
REQ-031 No cause: stall and bubble all 0; stall[i] and bubble[i] never both 1.
REQ-032 FSM states RUN=0, DWAIT=1, IWAIT=2, RHOLD=3; next state from current cycle's causes: dmiss->DWAIT; else redirect&imiss->RHOLD; else imiss->IWAIT; else RUN.
REQ-033 Watchdog counter increments each cycle state!=RUN, clears on RUN; reaching TIMEOUT sets hang, held until reset.
REQ-034 perf_cnt[k] increments once per cycle cause k wins priority; saturates at all-ones; perf_clr wins over increment.
REQ-035 Response arriving on request's first cycle gives zero stall cycles.

Reset
REQ-036 rst asserted: state=RUN, watchdog=0, hang=0, perf_cnt=0 immediately, regardless of clk.
REQ-037 rst mid-wait: in-flight miss abandoned, outputs follow REQ-025..031 from current inputs.

Structure
REQ-038 FSM state enum and perf index constants reside in rv32i_types.
REQ-039 One sub-module sat_counter (CNT_W, inc, clr), instanced four times.

Verification
REQ-040 d_read=1, d_resp low 3 cycles -> stall=5'b01111, bubble=5'b10000 for 3 cycles, state DWAIT, perf_cnt[0]=3.
REQ-041 ex_is_load, ex_rd=5, id_rs2=5 one cycle -> stall=5'b00011, bubble=5'b00100; ex_rd=0 -> no stall.
REQ-042 redirect with i_read, i_resp low 2 cycles -> stall=5'b00111 in RHOLD 2 cycles, then bubble=5'b00110.
REQ-043 dmiss+redirect+luse same cycle -> dmiss outputs only, perf_cnt[0] increments only.
REQ-044 TIMEOUT=4, d_resp never -> hang rises after 4 wait cycles, stays high after d_resp; rst clears.
REQ-045 CNT_W=3, 9 imiss cycles -> perf_cnt[1]=7; perf_clr with imiss -> 0.
